// File: rtl/pcie_lpif_tx_lane_striper_if.sv
// LPIF TX / PIPE TX bundle for pcie_lpif_tx_lane_striper.
// The slave modport is the striper itself. The master modport is the
// LP + LTSSM side that offers words and drives the stall request.
// fsm_state exposes the stall FSM for observation: 0 RUN, 1 REQ, 2 STALLED, 3 REL.
interface pcie_lpif_tx_lane_striper_if #(
  parameter int LANES      = 4,
  parameter int LANE_BYTES = 1,
  parameter int DEPTH      = 4
);
  localparam int NBYTES = LANES * LANE_BYTES;

  // Handshake: a word transfers on a rising CLK edge where lp_irdy and pl_trdy
  // are both 1. pl_trdy depends only on registered state, so lp_irdy may depend
  // on pl_trdy. lp_data and lp_valid must be stable while lp_irdy is 1. The
  // stall pair is a four-phase level handshake: pl_stallreq rises, then
  // lp_stallack rises, then pl_stallreq falls, then lp_stallack falls.
  logic                      lp_irdy;
  logic [NBYTES*8-1:0]       lp_data;
  logic [NBYTES-1:0]         lp_valid;
  logic                      pl_trdy;
  logic                      phy_stall_req;
  logic                      pl_stallreq;
  logic                      lp_stallack;
  logic                      stall_done;
  logic [NBYTES*8-1:0]       TxData;
  logic                      TxDataValid;
  logic                      TxElecIdle;
  logic [$clog2(DEPTH):0]    fifo_level;
  logic [1:0]                fsm_state;

  modport master (
    output lp_irdy, lp_data, lp_valid, phy_stall_req, lp_stallack,
    input  pl_trdy, pl_stallreq, stall_done, TxData, TxDataValid,
    input  TxElecIdle, fifo_level, fsm_state
  );

  modport slave (
    input  lp_irdy, lp_data, lp_valid, phy_stall_req, lp_stallack,
    output pl_trdy, pl_stallreq, stall_done, TxData, TxDataValid,
    output TxElecIdle, fifo_level, fsm_state
  );
endinterface

// File: rtl/pcie_lpif_tx_lane_striper.sv
// LPIF-to-PIPE transmit datapath: DEPTH-entry FIFO of lane-striped words,
// one pop per cycle while non-empty, plus the LPIF stall handshake FSM.
// Optional feature macro: PCIE_TX_EIDLE_TIMER_EN re-enters electrical idle
// after EIDLE_CYC cycles without data.
module pcie_lpif_tx_lane_striper #(
  parameter int         LANES      = 4,
  parameter int         LANE_BYTES = 1,
  parameter int         DEPTH      = 4,
  parameter logic [7:0] PAD_BYTE   = 8'h00,
  parameter int         EIDLE_CYC  = 16
) (
  input  logic                           CLK,
  input  logic                           reset,
  pcie_lpif_tx_lane_striper_if.slave     bus
);
  localparam int NBYTES = LANES * LANE_BYTES;
  localparam int W      = NBYTES * 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_REQ     = 2'd1,
    ST_STALLED = 2'd2,
    ST_REL     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            pl_stallreq_q, pl_stallreq_d;
  logic            stall_done_q, stall_done_d;

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [W-1:0]    txdata_q;
  logic            txvalid_q;
  logic            eidle_q;

  logic            trdy;
  logic            push;
  logic            pop;
  logic [W-1:0]    striped;

  // Handshake qualifiers come from registered state only; a full FIFO refuses
  // a word even when a pop happens on the same edge.
  assign trdy = (level_q != LW'(DEPTH)) && (state_q != ST_STALLED);
  assign push = bus.lp_irdy && trdy && (|bus.lp_valid);
  assign pop  = (level_q != '0);

  // Byte b goes to lane b%LANES, slot b/LANES; invalid bytes become PAD_BYTE.
  always_comb begin
    striped = '0;
    for (int b = 0; b < NBYTES; b++) begin
      striped[(((b % LANES) * LANE_BYTES) + (b / LANES)) * 8 +: 8] =
        bus.lp_valid[b] ? bus.lp_data[b*8 +: 8] : PAD_BYTE;
    end
  end

  // Occupancy after this edge: push and pop together leave it unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // FIFO storage; stale contents are harmless because reset clears the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= striped;
    end
  end

  // Pointers, occupancy and the registered PIPE data stage.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      txdata_q  <= '0;
      txvalid_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      txvalid_q <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        txdata_q <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Stall FSM next state and the registered stall outputs derived from it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (bus.phy_stall_req) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.lp_stallack) begin
          state_d = ST_STALLED;
        end else if (!bus.phy_stall_req) begin
          state_d = ST_REL;
        end
      end
      ST_STALLED: if (!bus.phy_stall_req) state_d = ST_REL;
      ST_REL:     if (!bus.lp_stallack) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
    pl_stallreq_d = (state_d == ST_REQ) || (state_d == ST_STALLED);
    stall_done_d  = (state_d == ST_STALLED) && (level_d == '0);
  end

  // Stall FSM state register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pl_stallreq_q <= 1'b0;
      stall_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pl_stallreq_q <= pl_stallreq_d;
      stall_done_q  <= stall_done_d;
    end
  end

`ifdef PCIE_TX_EIDLE_TIMER_EN
  localparam int CW = $clog2(EIDLE_CYC + 1);
  logic [CW-1:0] idle_cnt_q;

  // Count data-less cycles; saturating at EIDLE_CYC re-enters electrical idle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
      eidle_q    <= 1'b1;
    end else if (pop) begin
      idle_cnt_q <= '0;
      eidle_q    <= 1'b0;
    end else if (idle_cnt_q != CW'(EIDLE_CYC)) begin
      idle_cnt_q <= idle_cnt_q + CW'(1);
      if (idle_cnt_q == CW'(EIDLE_CYC - 1)) begin
        eidle_q <= 1'b1;
      end
    end
  end
`else
  // Electrical idle is left on the first data edge and not re-entered.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      eidle_q <= 1'b1;
    end else if (pop) begin
      eidle_q <= 1'b0;
    end
  end
`endif

  assign bus.pl_trdy     = trdy;
  assign bus.pl_stallreq = pl_stallreq_q;
  assign bus.stall_done  = stall_done_q;
  assign bus.TxData      = txdata_q;
  assign bus.TxDataValid = txvalid_q;
  assign bus.TxElecIdle  = eidle_q;
  assign bus.fifo_level  = level_q;
  assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_pcie_lpif_tx_lane_striper.sv
// Bench for pcie_lpif_tx_lane_striper: two instances (4x1 and 2x2 lane
// layouts, DEPTH 4) share one stimulus; a queue-based reference model
// predicts both every cycle. Honours PCIE_TX_EIDLE_TIMER_EN if defined.
module tb_pcie_lpif_tx_lane_striper;
  localparam int         W         = 32;
  localparam int         DEPTH     = 4;
  localparam int         EIDLE_CYC = 16;
  localparam logic [7:0] PAD       = 8'h00;

  localparam int P_RUN = 0, P_REQ = 1, P_STALLED = 2, P_REL = 3;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  logic          lp_irdy;
  logic [W-1:0]  lp_data;
  logic [3:0]    lp_valid;
  logic          phy_stall_req;
  logic          lp_stallack;

  pcie_lpif_tx_lane_striper_if #(.LANES(4), .LANE_BYTES(1), .DEPTH(DEPTH)) ifa ();
  pcie_lpif_tx_lane_striper_if #(.LANES(2), .LANE_BYTES(2), .DEPTH(DEPTH)) ifb ();

  assign ifa.lp_irdy = lp_irdy;        assign ifb.lp_irdy = lp_irdy;
  assign ifa.lp_data = lp_data;        assign ifb.lp_data = lp_data;
  assign ifa.lp_valid = lp_valid;      assign ifb.lp_valid = lp_valid;
  assign ifa.phy_stall_req = phy_stall_req;
  assign ifb.phy_stall_req = phy_stall_req;
  assign ifa.lp_stallack = lp_stallack;
  assign ifb.lp_stallack = lp_stallack;

  pcie_lpif_tx_lane_striper #(
    .LANES(4), .LANE_BYTES(1), .DEPTH(DEPTH), .PAD_BYTE(PAD), .EIDLE_CYC(EIDLE_CYC)
  ) dut_a (.CLK(CLK), .reset(reset), .bus(ifa));

  pcie_lpif_tx_lane_striper #(
    .LANES(2), .LANE_BYTES(2), .DEPTH(DEPTH), .PAD_BYTE(PAD), .EIDLE_CYC(EIDLE_CYC)
  ) dut_b (.CLK(CLK), .reset(reset), .bus(ifb));

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];
  int           m_phase;
  logic         m_txv, m_eidle, m_req, m_done;
  logic [W-1:0] m_txa, m_txb;
  int           m_idle;
  logic         done_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Place each byte by the lane/slot rule; invalid bytes become PAD.
  function automatic logic [31:0] stripe(input logic [31:0] d, input logic [3:0] v,
                                         input int lanes, input int lb);
    logic [31:0] r;
    int pos;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      pos = (b % lanes) * lb + b / lanes;
      r[pos*8 +: 8] = v[b] ? d[b*8 +: 8] : PAD;
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_qa.delete();
    exp_qb.delete();
    m_phase = P_RUN;
    m_txv = 1'b0; m_eidle = 1'b1; m_req = 1'b0; m_done = 1'b0;
    m_txa = '0; m_txb = '0; m_idle = 0;
  endtask

  // One clock edge of the transmit path as described by its rules.
  task automatic model_edge();
    logic can_take, take, emit;
    can_take = (exp_qa.size() < DEPTH) && (m_phase != P_STALLED);
    take     = lp_irdy && can_take && (lp_valid != 4'h0);
    emit     = exp_qa.size() > 0;
    if (emit) begin
      m_txa = exp_qa.pop_front();
      m_txb = exp_qb.pop_front();
      m_txv = 1'b1;
    end else begin
      m_txv = 1'b0;
    end
    if (take) begin
      exp_qa.push_back(stripe(lp_data, lp_valid, 4, 1));
      exp_qb.push_back(stripe(lp_data, lp_valid, 2, 2));
    end
`ifdef PCIE_TX_EIDLE_TIMER_EN
    if (emit) begin
      m_idle = 0;
      m_eidle = 1'b0;
    end else begin
      if (m_idle < EIDLE_CYC) m_idle++;
      if (m_idle >= EIDLE_CYC) m_eidle = 1'b1;
    end
`else
    if (emit) m_eidle = 1'b0;
`endif
    case (m_phase)
      P_RUN:     if (phy_stall_req) m_phase = P_REQ;
      P_REQ:     if (lp_stallack) m_phase = P_STALLED;
                 else if (!phy_stall_req) m_phase = P_REL;
      P_STALLED: if (!phy_stall_req) m_phase = P_REL;
      default:   if (!lp_stallack) m_phase = P_RUN;
    endcase
    m_req  = (m_phase == P_REQ) || (m_phase == P_STALLED);
    m_done = (m_phase == P_STALLED) && (exp_qa.size() == 0);
  endtask

  task automatic compare_all();
    logic exp_trdy;
    exp_trdy = (exp_qa.size() < DEPTH) && (m_phase != P_STALLED);
    check("a_level",  32'(ifa.fifo_level), 32'(exp_qa.size()));
    check("b_level",  32'(ifb.fifo_level), 32'(exp_qb.size()));
    check("a_txv",    32'(ifa.TxDataValid), 32'(m_txv));
    check("b_txv",    32'(ifb.TxDataValid), 32'(m_txv));
    check("a_txdata", ifa.TxData, m_txa);
    check("b_txdata", ifb.TxData, m_txb);
    check("a_eidle",  32'(ifa.TxElecIdle), 32'(m_eidle));
    check("b_eidle",  32'(ifb.TxElecIdle), 32'(m_eidle));
    check("a_trdy",   32'(ifa.pl_trdy), 32'(exp_trdy));
    check("b_trdy",   32'(ifb.pl_trdy), 32'(exp_trdy));
    check("stallreq", 32'(ifa.pl_stallreq), 32'(m_req));
    check("stalldone",32'(ifa.stall_done), 32'(m_done));
    if (ifa.stall_done) done_seen = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic irdy, input logic [31:0] d, input logic [3:0] v);
    lp_irdy = irdy; lp_data = d; lp_valid = v;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  typedef struct {
    logic        irdy;
    logic [31:0] data;
    logic [3:0]  valid;
    logic [2:0]  lvl;
    logic        txv;
    logic [31:0] txa;
    logic [31:0] txb;
    logic        eidle;
  } vec_t;

  vec_t tbl[4];

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{1'b1, 32'h44332211, 4'hF, 3'd1, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
    tbl[1] = '{1'b1, 32'hDDCCBBAA, 4'h5, 3'd1, 1'b1, 32'h44332211, 32'h44223311, 1'b0};
    tbl[2] = '{1'b1, 32'h12345678, 4'h0, 3'd0, 1'b1, 32'h00CC00AA, 32'h0000CCAA, 1'b0};
    tbl[3] = '{1'b0, 32'h00000000, 4'h0, 3'd0, 1'b0, 32'h00CC00AA, 32'h0000CCAA, 1'b0};

    reset = 1'b1;
    drive(1'b0, '0, '0);
    phy_stall_req = 1'b0;
    lp_stallack   = 1'b0;
    done_seen     = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    compare_all();
    check("rst_txdata_a", ifa.TxData, 32'h0);
    check("rst_eidle", 32'(ifa.TxElecIdle), 32'h1);

    // Stream and pad vectors from the table.
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].irdy, tbl[i].data, tbl[i].valid);
      step();
      check($sformatf("tbl%0d_level", i), 32'(ifa.fifo_level), 32'(tbl[i].lvl));
      check($sformatf("tbl%0d_txv", i),   32'(ifa.TxDataValid), 32'(tbl[i].txv));
      check($sformatf("tbl%0d_txa", i),   ifa.TxData, tbl[i].txa);
      check($sformatf("tbl%0d_txb", i),   ifb.TxData, tbl[i].txb);
      check($sformatf("tbl%0d_eidle", i), 32'(ifa.TxElecIdle), 32'(tbl[i].eidle));
    end

    // Five back-to-back words across the pointer wrap.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hA0B0C0D0 + 32'(i * 32'h01010101), 4'hF);
      step();
    end
    drive(1'b0, '0, '0);
    repeat (3) step();
    check("wrap_drained", 32'(ifa.fifo_level), 32'h0);

    // Stall: request while streaming, ack two cycles later.
    drive(1'b1, 32'h55667788, 4'hF);
    phy_stall_req = 1'b1;
    step();
    check("stall_req_up", 32'(ifa.pl_stallreq), 32'h1);
    repeat (2) begin
      drive(1'b1, $urandom, 4'hF);
      step();
    end
    lp_stallack = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 4'hF);
    step();
    check("stalled_trdy", 32'(ifa.pl_trdy), 32'h0);
    repeat (3) step();
    check("stalled_done", 32'(ifa.stall_done), 32'h1);
    check("stalled_level", 32'(ifa.fifo_level), 32'h0);
    phy_stall_req = 1'b0;
    drive(1'b0, '0, '0);
    step();
    check("rel_req_down", 32'(ifa.pl_stallreq), 32'h0);
    check("rel_done_down", 32'(ifa.stall_done), 32'h0);
    step();
    lp_stallack = 1'b0;
    step();
    check("run_trdy", 32'(ifa.pl_trdy), 32'h1);

    // Abort: request withdrawn before any ack.
    done_seen = 1'b0;
    phy_stall_req = 1'b1;
    drive(1'b1, 32'h0BADF00D, 4'h3);
    step();
    phy_stall_req = 1'b0;
    step();
    drive(1'b0, '0, '0);
    repeat (2) step();
    check("abort_no_done", 32'(done_seen), 32'h0);
    check("abort_req_low", 32'(ifa.pl_stallreq), 32'h0);

    // Reset mid-stream with words in flight.
    drive(1'b1, 32'h11112222, 4'hF);
    step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_mid_level", 32'(ifa.fifo_level), 32'h0);
    check("rst_mid_txv", 32'(ifa.TxDataValid), 32'h0);
    check("rst_mid_eidle", 32'(ifa.TxElecIdle), 32'h1);
    check("rst_mid_txdata", ifb.TxData, 32'h0);
    drive(1'b0, '0, '0);
    @(negedge CLK);
    reset = 1'b0;
    drive(1'b1, 32'hCAFEF00D, 4'hF);
    step();
    drive(1'b0, '0, '0);
    step();
    check("post_rst_word", ifa.TxData, 32'hCAFEF00D);
    check("post_rst_txv", 32'(ifa.TxDataValid), 32'h1);

    // Twenty idle cycles, then one word.
    repeat (20) step();
    drive(1'b1, 32'h01020304, 4'hF);
    step();
    drive(1'b0, '0, '0);
    step();
    check("idle_then_word_eidle", 32'(ifa.TxElecIdle), 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom,
            ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom));
      if ($urandom_range(0, 15) == 0) phy_stall_req = ~phy_stall_req;
      if ($urandom_range(0, 3) == 0) lp_stallack = m_req;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
